traffic_signal_monitor: RTL and testbench
=========================================

TRAFFIC_SIGNAL_MONITOR -- requirements
Module: traffic_signal_monitor

Interface
REQ-001 Parameter DURATION_GREEN, 40, green phase terminal count; the phase lasts DURATION_GREEN+1 cycles.
REQ-002 Parameter DURATION_YELLOW, 5, yellow phase terminal count; the phase lasts DURATION_YELLOW+1 cycles.
REQ-003 Parameter DURATION_LEFT, 20, left-turn phase terminal count; the phase lasts DURATION_LEFT+1 cycles.
REQ-004 Port list SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- north  in  2  light_t, north signal head.
- south  in  2  light_t, south signal head.
- east  in  2  light_t, east signal head.
- west  in  2  light_t, west signal head.
- err_clear  in  1  clears sticky error flags.
- locked  out  1  monitor is tracking the phase sequence.
- phase  out  3  phase_t, current decoded phase; valid when locked=1.
- phase_change  out  1  one-cycle pulse on each legal phase transition.
- dwell  out  8  cycles spent in the current phase; saturates at 255.
- cycles_done  out  16  completed full cycles; wraps modulo 2^16.
- err_conflict  out  1  sticky; an illegal signal pattern was seen.
- err_sequence  out  1  sticky; an out-of-order phase was seen.
- err_duration  out  1  sticky; a phase dwell count was wrong.

Function
REQ-005 Each edge SHALL classify {north,south,east,west} into one of the following patterns:
- NS_G: N=S=GREEN, E=W=RED.
- NS_Y: N=S=YELLOW, E=W=RED.
- NS_L: N=S=LEFT, E=W=RED.
- EW_G, EW_Y, EW_L: the same patterns with the pairs swapped.
- ALL_RED: all four heads RED.
- ILLEGAL: any other combination.
REQ-006 A legal phase order SHALL be NS_GREEN -> NS_YELLOW -> EW_LEFT -> EW_YELLOW -> EW_GREEN -> EW_YELLOW2 -> NS_LEFT -> NS_YELLOW2 -> NS_GREEN.
REQ-007 Yellow disambiguation SHALL depend on the preceding phase:
- NS_Y after NS_GREEN = NS_YELLOW; NS_Y after NS_LEFT = NS_YELLOW2.
- EW_Y after EW_LEFT = EW_YELLOW; EW_Y after EW_GREEN = EW_YELLOW2.
REQ-008 FSM states SHALL be SYNC and TRACK.
REQ-009 In SYNC, patterns ALL_RED, NS_Y and EW_Y SHALL be ignored.
- A G or L pattern SHALL set phase to match, set dwell=1 and go to TRACK.
- The first phase after acquisition SHALL be exempt from the duration check.
REQ-010 In TRACK, a pattern equal to the current phase SHALL increment dwell.
REQ-011 In TRACK, a pattern equal to the REQ-006 successor SHALL:
- advance phase and set dwell=1;
- pulse phase_change;
- check the exiting dwell against its DURATION+1.
REQ-012 In TRACK, any other G/Y/L or ALL_RED pattern SHALL set err_sequence and go to SYNC.
REQ-013 An ILLEGAL pattern in either state SHALL set err_conflict; in TRACK it SHALL also force SYNC.
REQ-014 err_duration SHALL set in either of these cases:
- at a transition, when the exiting dwell does not equal DURATION+1;
- immediately, when dwell reaches DURATION+2 in the current phase.
REQ-015 cycles_done SHALL increment on each NS_YELLOW2 -> NS_GREEN transition.
REQ-016 All outputs SHALL be registered; a pattern sampled at edge k SHALL be reflected in the outputs after edge k (latency 1).
REQ-017 err_clear SHALL clear all three error flags; an error event in the same cycle SHALL take priority, leaving that flag set.
REQ-018 Parameters SHALL be at most 253 so that DURATION+2 fits in 8 bits.

Reset
REQ-019 rst=1 at an edge SHALL force the following values, with rst taking priority over all other inputs:
- state SYNC, locked 0, phase NS_GREEN (3'd0);
- dwell 0, cycles_done 0, phase_change 0;
- all error flags 0.
REQ-020 Reset asserted mid-phase SHALL discard the phase and dwell; re-acquisition SHALL follow REQ-009.

Structure
REQ-021 Shared package traffic_pkg SHALL hold the following:
- light_t (GREEN=0, YELLOW=1, RED=2, LEFT=3);
- phase_t (NS_GREEN=0, NS_YELLOW=1, NS_LEFT=2, NS_YELLOW2=3, EW_LEFT=4, EW_YELLOW=5, EW_GREEN=6, EW_YELLOW2=7);
- the default duration constants.
REQ-022 Pattern classification SHALL be a combinational sub-module, traffic_pattern_decode.

Verification
REQ-023 Correct sequence with default durations over 2 full cycles:
- locked=1 after the first NS_G;
- 16 phase_change pulses;
- cycles_done=2;
- all error flags 0.
REQ-024 Hold EW_G for 42 cycles instead of 41:
- err_duration=1 at the 42nd cycle;
- locked stays 1.
REQ-025 Drive N=GREEN with E=GREEN:
- err_conflict=1 and locked=0 at the next edge;
- re-lock on the next G/L pattern.
REQ-026 Drive NS_GREEN -> EW_G directly:
- err_sequence=1 and locked=0;
- err_clear with no new error clears the flag one edge later.
REQ-027 Assert rst for 1 cycle mid-EW_LEFT:
- all outputs return to their reset values;
- an EW_Y pattern is ignored;
- lock occurs at EW_G with dwell=1.
REQ-028 Run 65536 full cycles: cycles_done wraps to 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic signal monitor: light encodings, phases, decoded patterns.
// Also holds the fixed phase order and the default phase durations.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2,
        LEFT   = 2'd3
    } light_t;

    typedef enum logic [2:0] {
        NS_GREEN   = 3'd0,
        NS_YELLOW  = 3'd1,
        NS_LEFT    = 3'd2,
        NS_YELLOW2 = 3'd3,
        EW_LEFT    = 3'd4,
        EW_YELLOW  = 3'd5,
        EW_GREEN   = 3'd6,
        EW_YELLOW2 = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        PAT_NS_G,
        PAT_NS_Y,
        PAT_NS_L,
        PAT_EW_G,
        PAT_EW_Y,
        PAT_EW_L,
        PAT_ALL_RED,
        PAT_ILLEGAL
    } pattern_t;

    typedef enum logic {
        ST_SYNC,
        ST_TRACK
    } mon_state_t;

    localparam int DEF_DURATION_GREEN  = 40;
    localparam int DEF_DURATION_YELLOW = 5;
    localparam int DEF_DURATION_LEFT   = 20;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            NS_GREEN:   return NS_YELLOW;
            NS_YELLOW:  return EW_LEFT;
            EW_LEFT:    return EW_YELLOW;
            EW_YELLOW:  return EW_GREEN;
            EW_GREEN:   return EW_YELLOW2;
            EW_YELLOW2: return NS_LEFT;
            NS_LEFT:    return NS_YELLOW2;
            default:    return NS_GREEN;
        endcase
    endfunction

    // Both yellow phases of a pair share one light pattern.
    function automatic pattern_t phase_pattern(input phase_t p);
        case (p)
            NS_GREEN:               return PAT_NS_G;
            NS_YELLOW, NS_YELLOW2:  return PAT_NS_Y;
            NS_LEFT:                return PAT_NS_L;
            EW_GREEN:               return PAT_EW_G;
            EW_YELLOW, EW_YELLOW2:  return PAT_EW_Y;
            default:                return PAT_EW_L;
        endcase
    endfunction

endpackage

// File: rtl/traffic_pattern_decode.sv
// Classifies the four signal heads into one pattern; purely combinational.
// Latency 0; no backpressure.
module traffic_pattern_decode
    import traffic_pkg::*;
(
    input  logic [1:0] north,
    input  logic [1:0] south,
    input  logic [1:0] east,
    input  logic [1:0] west,
    output pattern_t   pattern
);

    logic ns_red;
    logic ew_red;

    assign ns_red = (north == RED) && (south == RED);
    assign ew_red = (east == RED) && (west == RED);

    always_comb begin
        pattern = PAT_ILLEGAL;
        if (ns_red && ew_red) begin
            pattern = PAT_ALL_RED;
        end else if (ew_red && (north == south)) begin
            case (north)
                GREEN:   pattern = PAT_NS_G;
                YELLOW:  pattern = PAT_NS_Y;
                LEFT:    pattern = PAT_NS_L;
                default: pattern = PAT_ILLEGAL;
            endcase
        end else if (ns_red && (east == west)) begin
            case (east)
                GREEN:   pattern = PAT_EW_G;
                YELLOW:  pattern = PAT_EW_Y;
                LEFT:    pattern = PAT_EW_L;
                default: pattern = PAT_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/traffic_signal_monitor.sv
// Tracks the intersection phase sequence and flags conflicts, order and timing errors.
// Latency 1 cycle from sampled lights to all outputs; free-running, no backpressure.
module traffic_signal_monitor
    import traffic_pkg::*;
#(
    parameter int DURATION_GREEN  = DEF_DURATION_GREEN,
    parameter int DURATION_YELLOW = DEF_DURATION_YELLOW,
    parameter int DURATION_LEFT   = DEF_DURATION_LEFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  north,
    input  logic [1:0]  south,
    input  logic [1:0]  east,
    input  logic [1:0]  west,
    input  logic        err_clear,
    output logic        locked,
    output logic [2:0]  phase,
    output logic        phase_change,
    output logic [7:0]  dwell,
    output logic [15:0] cycles_done,
    output logic        err_conflict,
    output logic        err_sequence,
    output logic        err_duration
);

    // Expected dwell (cycles) of each phase class; durations must stay <= 253.
    localparam logic [7:0] LIM_GREEN  = 8'(DURATION_GREEN + 1);
    localparam logic [7:0] LIM_YELLOW = 8'(DURATION_YELLOW + 1);
    localparam logic [7:0] LIM_LEFT   = 8'(DURATION_LEFT + 1);

    pattern_t   pat;
    mon_state_t state_q, state_d;
    phase_t     phase_q, phase_d;
    phase_t     nxt_ph;
    phase_t     acq_ph;
    logic       locked_q, locked_d;
    logic       pc_q, pc_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] dwell_inc;
    logic [7:0] cur_lim;
    logic [15:0] cycles_q, cycles_d;
    logic       err_conf_q, err_conf_d;
    logic       err_seq_q, err_seq_d;
    logic       err_dur_q, err_dur_d;
    logic       exempt_q, exempt_d;
    logic       conf_ev, seq_ev, dur_ev;
    logic       acq, drop;

    traffic_pattern_decode u_decode (
        .north   (north),
        .south   (south),
        .east    (east),
        .west    (west),
        .pattern (pat)
    );

    always_comb begin
        case (phase_q)
            NS_GREEN, EW_GREEN:                         cur_lim = LIM_GREEN;
            NS_YELLOW, NS_YELLOW2, EW_YELLOW, EW_YELLOW2: cur_lim = LIM_YELLOW;
            default:                                    cur_lim = LIM_LEFT;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        locked_d  = locked_q;
        pc_d      = 1'b0;
        dwell_d   = dwell_q;
        cycles_d  = cycles_q;
        exempt_d  = exempt_q;
        conf_ev   = 1'b0;
        seq_ev    = 1'b0;
        dur_ev    = 1'b0;
        acq       = 1'b0;
        acq_ph    = NS_GREEN;
        drop      = 1'b0;
        nxt_ph    = next_phase(phase_q);
        dwell_inc = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;

        case (state_q)
            ST_SYNC: begin
                case (pat)
                    PAT_NS_G:    begin acq = 1'b1; acq_ph = NS_GREEN; end
                    PAT_NS_L:    begin acq = 1'b1; acq_ph = NS_LEFT;  end
                    PAT_EW_G:    begin acq = 1'b1; acq_ph = EW_GREEN; end
                    PAT_EW_L:    begin acq = 1'b1; acq_ph = EW_LEFT;  end
                    PAT_ILLEGAL: conf_ev = 1'b1;
                    default:     ;
                endcase
                if (acq) begin
                    state_d  = ST_TRACK;
                    locked_d = 1'b1;
                    phase_d  = acq_ph;
                    dwell_d  = 8'd1;
                    // Lock may land mid-phase, so its length is unknown.
                    exempt_d = 1'b1;
                end
            end
            default: begin
                if (pat == PAT_ILLEGAL) begin
                    conf_ev = 1'b1;
                    drop    = 1'b1;
                end else if (pat == phase_pattern(phase_q)) begin
                    dwell_d = dwell_inc;
                    if (!exempt_q && (dwell_inc == cur_lim + 8'd1)) begin
                        dur_ev = 1'b1;
                    end
                end else if (pat == phase_pattern(nxt_ph)) begin
                    phase_d  = nxt_ph;
                    dwell_d  = 8'd1;
                    pc_d     = 1'b1;
                    exempt_d = 1'b0;
                    if (!exempt_q && (dwell_q != cur_lim)) begin
                        dur_ev = 1'b1;
                    end
                    if (phase_q == NS_YELLOW2) begin
                        cycles_d = cycles_q + 16'd1;
                    end
                end else begin
                    seq_ev = 1'b1;
                    drop   = 1'b1;
                end
                if (drop) begin
                    state_d  = ST_SYNC;
                    locked_d = 1'b0;
                    dwell_d  = 8'd0;
                    exempt_d = 1'b0;
                end
            end
        endcase

        // A new error outranks a simultaneous clear.
        err_conf_d = conf_ev | (err_conf_q & ~err_clear);
        err_seq_d  = seq_ev  | (err_seq_q  & ~err_clear);
        err_dur_d  = dur_ev  | (err_dur_q  & ~err_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            phase_q    <= NS_GREEN;
            locked_q   <= 1'b0;
            pc_q       <= 1'b0;
            dwell_q    <= 8'd0;
            cycles_q   <= 16'd0;
            exempt_q   <= 1'b0;
            err_conf_q <= 1'b0;
            err_seq_q  <= 1'b0;
            err_dur_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            locked_q   <= locked_d;
            pc_q       <= pc_d;
            dwell_q    <= dwell_d;
            cycles_q   <= cycles_d;
            exempt_q   <= exempt_d;
            err_conf_q <= err_conf_d;
            err_seq_q  <= err_seq_d;
            err_dur_q  <= err_dur_d;
        end
    end

    assign locked       = locked_q;
    assign phase        = phase_q;
    assign phase_change = pc_q;
    assign dwell        = dwell_q;
    assign cycles_done  = cycles_q;
    assign err_conflict = err_conf_q;
    assign err_sequence = err_seq_q;
    assign err_duration = err_dur_q;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Self-checking bench for traffic_signal_monitor: vector table plus long legal-sequence runs.
module tb_traffic_signal_monitor;
    import traffic_pkg::*;

    localparam int P_NS_G = 0, P_NS_Y = 1, P_NS_L = 2, P_EW_G = 3;
    localparam int P_EW_Y = 4, P_EW_L = 5, P_ALL_RED = 6, P_ILL = 7;

    typedef struct packed {
        logic        lk;
        logic [2:0]  ph;
        logic        pc;
        logic [7:0]  dw;
        logic [15:0] cyc;
        logic [2:0]  err;   // {conflict, sequence, duration}
    } exp_t;

    typedef struct {
        int   pat;
        logic clr;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  north, south, east, west;
    logic        err_clear;
    logic        locked;
    logic [2:0]  phase;
    logic        phase_change;
    logic [7:0]  dwell;
    logic [15:0] cycles_done;
    logic        err_conflict, err_sequence, err_duration;

    int          checks = 0;
    int          errors = 0;
    int          pc_seen = 0;
    exp_t        exp_q[$];
    logic [15:0] e_cyc;
    logic [2:0]  e_err;
    vec_t        tbl[28];

    logic [2:0] ord_ph  [8] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3};
    int         ord_pat [8] = '{P_NS_G, P_NS_Y, P_EW_L, P_EW_Y, P_EW_G, P_EW_Y, P_NS_L, P_NS_Y};
    int         ord_len [8] = '{41, 6, 21, 6, 41, 6, 21, 6};

    always #5 clk = ~clk;

    traffic_signal_monitor #(
        .DURATION_GREEN  (40),
        .DURATION_YELLOW (5),
        .DURATION_LEFT   (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .north        (north),
        .south        (south),
        .east         (east),
        .west         (west),
        .err_clear    (err_clear),
        .locked       (locked),
        .phase        (phase),
        .phase_change (phase_change),
        .dwell        (dwell),
        .cycles_done  (cycles_done),
        .err_conflict (err_conflict),
        .err_sequence (err_sequence),
        .err_duration (err_duration)
    );

    function automatic exp_t mk(input logic lk, input logic [2:0] ph, input logic pc,
                                input logic [7:0] dw, input logic [15:0] cyc, input logic [2:0] err);
        mk = {lk, ph, pc, dw, cyc, err};
    endfunction

    task automatic lights(input logic [1:0] n, input logic [1:0] s, input logic [1:0] e, input logic [1:0] w);
        north = n; south = s; east = e; west = w;
    endtask

    task automatic set_lights(input int code);
        case (code)
            P_NS_G:    lights(GREEN,  GREEN,  RED,    RED);
            P_NS_Y:    lights(YELLOW, YELLOW, RED,    RED);
            P_NS_L:    lights(LEFT,   LEFT,   RED,    RED);
            P_EW_G:    lights(RED,    RED,    GREEN,  GREEN);
            P_EW_Y:    lights(RED,    RED,    YELLOW, YELLOW);
            P_EW_L:    lights(RED,    RED,    LEFT,   LEFT);
            P_ALL_RED: lights(RED,    RED,    RED,    RED);
            default:   lights(GREEN,  RED,    GREEN,  RED);
        endcase
    endtask

    task automatic check_out(input string nm);
        exp_t got;
        exp_t x;
        got = {locked, phase, phase_change, dwell, cycles_done, err_conflict, err_sequence, err_duration};
        if (phase_change) pc_seen++;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: output seen with no expected entry queued", nm);
        end else begin
            x = exp_q.pop_front();
            if (got !== x) begin
                errors++;
                $display("FAIL %s: got lk=%0b ph=%0d pc=%0b dw=%0d cyc=%0d err=%b, required lk=%0b ph=%0d pc=%0b dw=%0d cyc=%0d err=%b",
                         nm, got.lk, got.ph, got.pc, got.dw, got.cyc, got.err,
                         x.lk, x.ph, x.pc, x.dw, x.cyc, x.err);
            end
        end
    endtask

    task automatic step(input int code, input logic clr, input logic r, input exp_t e, input string nm);
        @(negedge clk);
        set_lights(code);
        err_clear = clr;
        rst       = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    // Drives one legal phase for n cycles; dur_at is the cycle where err_duration must rise.
    task automatic run_phase(input int idx, input int n, input logic pc_first, input int dur_at);
        logic       pc;
        logic [7:0] dw;
        for (int k = 1; k <= n; k++) begin
            pc = (k == 1) && pc_first;
            if (pc && idx == 0) e_cyc = e_cyc + 16'd1;
            if (k == dur_at) e_err[0] = 1'b1;
            dw = (k > 255) ? 8'd255 : 8'(k);
            step(ord_pat[idx], 1'b0, 1'b0, mk(1'b1, ord_ph[idx], pc, dw, e_cyc, e_err),
                 $sformatf("ph%0d_k%0d", idx, k));
        end
    endtask

    initial begin
        rst = 1'b1;
        err_clear = 1'b0;
        set_lights(P_ALL_RED);

        tbl[0]  = '{P_ALL_RED, 1'b0, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000)};
        tbl[1]  = '{P_NS_Y,    1'b0, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000)};
        tbl[2]  = '{P_EW_Y,    1'b0, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000)};
        tbl[3]  = '{P_ILL,     1'b0, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b100)};
        tbl[4]  = '{P_ALL_RED, 1'b1, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000)};
        tbl[5]  = '{P_NS_G,    1'b0, mk(1, 3'd0, 0, 8'd1, 16'd0, 3'b000)};
        tbl[6]  = '{P_NS_G,    1'b0, mk(1, 3'd0, 0, 8'd2, 16'd0, 3'b000)};
        tbl[7]  = '{P_ILL,     1'b0, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b100)};
        tbl[8]  = '{P_EW_L,    1'b0, mk(1, 3'd4, 0, 8'd1, 16'd0, 3'b100)};
        tbl[9]  = '{P_EW_L,    1'b1, mk(1, 3'd4, 0, 8'd2, 16'd0, 3'b000)};
        tbl[10] = '{P_EW_G,    1'b0, mk(0, 3'd4, 0, 8'd0, 16'd0, 3'b010)};
        tbl[11] = '{P_ALL_RED, 1'b1, mk(0, 3'd4, 0, 8'd0, 16'd0, 3'b000)};
        tbl[12] = '{P_NS_G,    1'b0, mk(1, 3'd0, 0, 8'd1, 16'd0, 3'b000)};
        tbl[13] = '{P_EW_G,    1'b0, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b010)};
        tbl[14] = '{P_ALL_RED, 1'b1, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000)};
        tbl[15] = '{P_NS_G,    1'b0, mk(1, 3'd0, 0, 8'd1, 16'd0, 3'b000)};
        tbl[16] = '{P_ILL,     1'b1, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b100)};
        tbl[17] = '{P_ALL_RED, 1'b1, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000)};
        tbl[18] = '{P_NS_G,    1'b0, mk(1, 3'd0, 0, 8'd1, 16'd0, 3'b000)};
        tbl[19] = '{P_NS_Y,    1'b0, mk(1, 3'd1, 1, 8'd1, 16'd0, 3'b000)};
        tbl[20] = '{P_NS_Y,    1'b0, mk(1, 3'd1, 0, 8'd2, 16'd0, 3'b000)};
        tbl[21] = '{P_EW_L,    1'b0, mk(1, 3'd4, 1, 8'd1, 16'd0, 3'b001)};
        tbl[22] = '{P_ALL_RED, 1'b0, mk(0, 3'd4, 0, 8'd0, 16'd0, 3'b011)};
        tbl[23] = '{P_ALL_RED, 1'b1, mk(0, 3'd4, 0, 8'd0, 16'd0, 3'b000)};
        tbl[24] = '{P_NS_L,    1'b0, mk(1, 3'd2, 0, 8'd1, 16'd0, 3'b000)};
        tbl[25] = '{P_NS_Y,    1'b0, mk(1, 3'd3, 1, 8'd1, 16'd0, 3'b000)};
        tbl[26] = '{P_NS_G,    1'b0, mk(1, 3'd0, 1, 8'd1, 16'd1, 3'b001)};
        tbl[27] = '{P_NS_G,    1'b0, mk(1, 3'd0, 0, 8'd2, 16'd1, 3'b001)};

        // Reset wins over both a lockable and an illegal pattern.
        step(P_NS_G, 1'b0, 1'b1, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000), "reset_a");
        step(P_ILL,  1'b1, 1'b1, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000), "reset_b");

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].pat, tbl[i].clr, 1'b0, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Two full legal cycles with default durations.
        step(P_ALL_RED, 1'b0, 1'b1, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000), "reset_c");
        e_cyc = 16'd0;
        e_err = 3'b000;
        pc_seen = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++) begin
                run_phase(i, ord_len[i], !(pass == 0 && i == 0), 0);
            end
        end
        run_phase(0, 41, 1'b1, 0);
        checks++;
        if (pc_seen != 16) begin
            errors++;
            $display("FAIL pc_count: got %0d pulses, required 16", pc_seen);
        end

        // EW_GREEN held one cycle too long; lock must survive.
        run_phase(1, 6, 1'b1, 0);
        run_phase(2, 21, 1'b1, 0);
        run_phase(3, 6, 1'b1, 0);
        run_phase(4, 42, 1'b1, 42);
        run_phase(5, 6, 1'b1, 0);
        run_phase(6, 21, 1'b1, 0);
        run_phase(7, 6, 1'b1, 0);
        run_phase(0, 41, 1'b1, 0);
        run_phase(1, 6, 1'b1, 0);
        run_phase(2, 10, 1'b1, 0);

        // Reset mid EW_LEFT, EW_Y ignored, relock at EW_GREEN.
        step(P_EW_L, 1'b0, 1'b1, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000), "mid_rst");
        e_cyc = 16'd0;
        e_err = 3'b000;
        for (int i = 0; i < 6; i++) begin
            step(P_EW_Y, 1'b0, 1'b0, mk(0, 3'd0, 0, 8'd0, 16'd0, 3'b000), $sformatf("sync_ewy%0d", i));
        end
        run_phase(4, 3, 1'b0, 0);
        // Short first phase is exempt; the overlong yellow flags at dwell 7 and saturates.
        run_phase(5, 300, 1'b1, 7);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
